alu_writeback_stage: RTL and testbench

ALU_WRITEBACK_STAGE -- requirements
Module: alu_writeback_stage

---
 rtl/alu_writeback_stage.sv | 103 ++++++++++
 tb/tb_alu_writeback_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_stage.sv
`default_nettype none
// ============================================================================
// alu_writeback_stage : 2-entry write-back FIFO, optional flags (WB_FLAG_REG_EN)
// Revision 1.0
// ============================================================================
module alu_writeback_stage #(
    parameter int WORD_SIZE  = 19,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_SIZE-1:0]  in_result,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic                  in_wen,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [WORD_SIZE-1:0]  wb_data,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [1:0]            occupancy,
    output logic                  flag_z,
    output logic                  flag_n
);

    localparam logic [1:0] c_DEPTH = 2'd2;

    logic [WORD_SIZE-1:0]  r_result [2];
    logic [REG_ADDR_W-1:0] r_dest   [2];
    logic [1:0]            r_wen;
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;

    logic w_head_valid;
    logic w_head_wen;
    logic w_retire;
    logic w_accept;

    // Gating the head with rst keeps discarded entries off the write port.
    assign w_head_valid = (r_count != 2'd0) && !rst;
    assign w_head_wen   = r_wen[r_rptr];
    assign w_retire     = w_head_valid && (!w_head_wen || wb_ready);
    assign in_ready     = !rst && ((r_count < c_DEPTH) || w_retire);
    assign w_accept     = in_valid && in_ready;

    assign wb_valid  = w_head_valid && w_head_wen;
    assign wb_data   = wb_valid ? r_result[r_rptr] : '0;
    assign wb_addr   = wb_valid ? r_dest[r_rptr]   : '0;
    assign occupancy = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_accept) begin
                r_wptr <= ~r_wptr;
            end
            if (w_retire) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_accept, w_retire})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_result[r_wptr] <= in_result;
            r_dest[r_wptr]   <= in_dest;
            r_wen[r_wptr]    <= in_wen;
        end
    end

`ifdef WB_FLAG_REG_EN
    logic r_flag_z;
    logic r_flag_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (w_retire) begin
            r_flag_z <= (r_result[r_rptr] == '0);
            r_flag_n <= r_result[r_rptr][WORD_SIZE-1];
        end
    end

    assign flag_z = r_flag_z;
    assign flag_n = r_flag_n;
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback_stage.sv
`default_nettype none
// ============================================================================
// tb_alu_writeback_stage : queue-model self-checking bench for the WB FIFO
// Revision 1.0
// ============================================================================
module tb_alu_writeback_stage;

    localparam int WS = 19;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [WS-1:0] in_result;
    logic [AW-1:0] in_dest;
    logic          in_wen;
    logic          wb_valid;
    logic          wb_ready;
    logic [WS-1:0] wb_data;
    logic [AW-1:0] wb_addr;
    logic [1:0]    occupancy;
    logic          flag_z;
    logic          flag_n;

    alu_writeback_stage #(.WORD_SIZE(WS), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_dest(in_dest), .in_wen(in_wen),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_addr(wb_addr),
        .occupancy(occupancy), .flag_z(flag_z), .flag_n(flag_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WS-1:0] res;
        logic [AW-1:0] dest;
        logic          wen;
    } ent_t;

    ent_t q[$];
    logic exp_fz = 1'b0;
    logic exp_fn = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_wb_count = 0;
    int   dut_wb_count = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check outputs against the queue model, advance.
    task automatic cycle(input logic r, input logic v, input logic [WS-1:0] res,
                         input logic [AW-1:0] d, input logic w, input logic wbr);
        ent_t h;
        logic hv, ret, exp_rdy, acc;
        rst = r; in_valid = v; in_result = res; in_dest = d; in_wen = w; wb_ready = wbr;
        #2;
        hv      = (q.size() != 0) && !r;
        h       = hv ? q[0] : '0;
        ret     = hv && (!h.wen || wbr);
        exp_rdy = !r && ((q.size() < 2) || ret);
        acc     = v && exp_rdy;
        check_value("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check_value("wb_valid", {31'd0, wb_valid}, {31'd0, hv && h.wen});
        if ((hv && h.wen) || q.size() == 0 || r) begin
            check_value("wb_data", {13'd0, wb_data}, (hv && h.wen) ? {13'd0, h.res} : 32'd0);
            check_value("wb_addr", {28'd0, wb_addr}, (hv && h.wen) ? {28'd0, h.dest} : 32'd0);
        end
        if (!r) begin
            check_value("occupancy", {30'd0, occupancy}, q.size());
            check_value("flag_z", {31'd0, flag_z}, {31'd0, exp_fz});
            check_value("flag_n", {31'd0, flag_n}, {31'd0, exp_fn});
        end
        if (wb_valid && wbr) dut_wb_count++;
        if (r) begin
            q.delete();
            exp_fz = 1'b0;
            exp_fn = 1'b0;
        end else begin
            if (ret) begin
                void'(q.pop_front());
                if (h.wen) model_wb_count++;
`ifdef WB_FLAG_REG_EN
                exp_fz = (h.res == '0);
                exp_fn = h.res[WS-1];
`endif
            end
            if (acc) q.push_back('{res: res, dest: d, wen: w});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic wbr, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, wbr);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_dest = '0; in_wen = 1'b0; wb_ready = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);

        // Single write-back entry, one-cycle latency.
        cycle(1'b0, 1'b1, 19'h00005, 4'd3, 1'b1, 1'b1);
        idle(1'b1, 2);

        // Back-pressure: fill, third push ignored, then drain.
        cycle(1'b0, 1'b1, 19'h00001, 4'd1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 19'h00002, 4'd2, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 19'h00003, 4'd4, 1'b1, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 3);

        // Full with simultaneous retire and accept.
        cycle(1'b0, 1'b1, 19'h00011, 4'd5, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 19'h00012, 4'd6, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 19'h40000, 4'd7, 1'b1, 1'b1);
        idle(1'b1, 4);

        // Flags-only entry retires without write-back.
        cycle(1'b0, 1'b1, 19'h00000, 4'd8, 1'b0, 1'b0);
        idle(1'b0, 2);

        // Reset while full discards both entries.
        cycle(1'b0, 1'b1, 19'h00021, 4'd9, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 19'h00022, 4'd10, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(1'b1, 3);

        for (int i = 0; i < 10000; i++) begin
            logic [WS-1:0] r;
            int sel;
            sel = $urandom_range(0, 3);
            r = WS'($urandom);
            if (sel == 0) r = '0;
            else if (sel == 1) r[WS-1] = 1'b1;
            cycle(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 9) < 7),
                  r, AW'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) < 6));
        end
        idle(1'b1, 4);
        check_value("wb_count", dut_wb_count, model_wb_count);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
